// File: rtl/bp_cce_pkg.sv
// Shared types and defaults for the CCE boot-time config loader.
// The readback check is enabled by defining BP_CCE_CFG_VERIFY_EN.
package bp_cce_pkg;

    typedef enum logic [2:0] {
        e_reset    = 3'd0,
        e_fetch    = 3'd1,
        e_rom_wait = 3'd2,
        e_send     = 3'd3,
        e_mode     = 3'd4,
        e_rd       = 3'd5,
        e_rd_wait  = 3'd6,
        e_done     = 3'd7
    } bp_cce_cfg_loader_state_e;

    localparam int cfg_instr_base_addr_gp = 'h4000;
    localparam int cfg_mode_addr_gp       = 'h0000;
    localparam int cfg_mode_normal_gp     = 1;

    // Counter/select width that stays at least one bit for a count of 1.
    function automatic int safe_clog2(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bp_cce_cfg_link_master.sv
// Single outstanding config request held until the selected CCE accepts it,
// fanned out one-hot to the CCE chosen at load time.
module bp_cce_cfg_link_master
    import bp_cce_pkg::*;
#(
    parameter int num_cce_p   = 1,
    parameter int sel_width_p = 1,
    parameter int addr_w_p    = 15,
    parameter int data_w_p    = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          load,
    input  logic [addr_w_p-1:0]           load_addr,
    input  logic [data_w_p-1:0]           load_data,
    input  logic                          load_w,
    input  logic [sel_width_p-1:0]        load_sel,
    input  logic [num_cce_p-1:0]          ready,
    output logic [num_cce_p*addr_w_p-1:0] addr,
    output logic [num_cce_p*data_w_p-1:0] data,
    output logic [num_cce_p-1:0]          v,
    output logic [num_cce_p-1:0]          w,
    output logic                          fire
);

    logic [addr_w_p-1:0]    addr_r;
    logic [data_w_p-1:0]    data_r;
    logic                   w_r;
    logic                   v_r;
    logic [sel_width_p-1:0] sel_r;
    logic [num_cce_p-1:0]   sel_onehot;

    always_comb begin
        sel_onehot = '0;
        for (int i = 0; i < num_cce_p; i++) begin
            sel_onehot[i] = (sel_r == sel_width_p'(i));
        end
    end

    // Ready from a CCE that is not the target never completes the request.
    assign fire = v_r & (|(sel_onehot & ready));

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_r <= '0;
            data_r <= '0;
            w_r    <= 1'b0;
            v_r    <= 1'b0;
            sel_r  <= '0;
        end else if (load) begin
            addr_r <= load_addr;
            data_r <= load_data;
            w_r    <= load_w;
            v_r    <= 1'b1;
            sel_r  <= load_sel;
        end else if (fire) begin
            v_r <= 1'b0;
        end
    end

    always_comb begin
        addr = '0;
        data = '0;
        v    = '0;
        w    = '0;
        for (int i = 0; i < num_cce_p; i++) begin
            addr[i*addr_w_p +: addr_w_p] = addr_r;
            data[i*data_w_p +: data_w_p] = data_r;
            v[i] = v_r & sel_onehot[i];
            w[i] = v_r & w_r & sel_onehot[i];
        end
    end

endmodule

// File: rtl/bp_cce_cfg_loader.sv
// Boot sequencer: streams the microcode image from the boot ROM into each
// CCE, sets its mode to normal, then drops freeze. BP_CCE_CFG_VERIFY_EN adds readback.
// Request handshake: a request is presented with v and held unchanged until the
// cycle in which v and the selected CCE's ready are both 1; that cycle transfers it.
module bp_cce_cfg_loader
    import bp_cce_pkg::*;
#(
    parameter int num_cce_p             = 1,
    parameter int num_instr_p           = 256,
    parameter int cfg_link_addr_width_p = 16,
    parameter int cfg_link_data_width_p = 64,
    parameter int instr_base_addr_p     = cfg_instr_base_addr_gp,
    parameter int mode_addr_p           = cfg_mode_addr_gp,
    parameter int mode_normal_p         = cfg_mode_normal_gp
) (
    input  logic                                                clk_i,
    input  logic                                                reset_i,
    output logic [safe_clog2(num_instr_p)-1:0]                  boot_rom_addr_o,
    input  logic [cfg_link_data_width_p-1:0]                    boot_rom_data_i,
    output logic [num_cce_p*(cfg_link_addr_width_p-1)-1:0]      config_addr_o,
    output logic [num_cce_p*cfg_link_data_width_p-1:0]          config_data_o,
    output logic [num_cce_p-1:0]                                config_v_o,
    output logic [num_cce_p-1:0]                                config_w_o,
    input  logic [num_cce_p-1:0]                                config_ready_i,
    input  logic [num_cce_p*cfg_link_data_width_p-1:0]          config_data_i,
    input  logic [num_cce_p-1:0]                                config_v_i,
    output logic [num_cce_p-1:0]                                config_ready_o,
    output logic                                                freeze_o,
    output logic                                                done_o,
    output logic                                                error_o,
    output logic [2:0]                                          state_o
);

    localparam int instr_w_lp = safe_clog2(num_instr_p);
    localparam int cce_w_lp   = safe_clog2(num_cce_p);
    localparam int addr_w_lp  = cfg_link_addr_width_p - 1;
    localparam int dw_lp      = cfg_link_data_width_p;

    localparam logic [2:0] s_reset    = e_reset;
    localparam logic [2:0] s_fetch    = e_fetch;
    localparam logic [2:0] s_rom_wait = e_rom_wait;
    localparam logic [2:0] s_send     = e_send;
    localparam logic [2:0] s_mode     = e_mode;
    localparam logic [2:0] s_done     = e_done;
`ifdef BP_CCE_CFG_VERIFY_EN
    localparam logic [2:0] s_rd       = e_rd;
    localparam logic [2:0] s_rd_wait  = e_rd_wait;
`endif

    logic [2:0]            state_r, state_n;
    logic [instr_w_lp-1:0] instr_cnt_r;
    logic [cce_w_lp-1:0]   cce_cnt_r;
    logic                  instr_last, cce_last, word_done;
    logic                  load, load_w, fire;
    logic [addr_w_lp-1:0]  load_addr, instr_addr;
    logic [dw_lp-1:0]      load_data;

    assign instr_last = (instr_cnt_r == instr_w_lp'(num_instr_p - 1));
    assign cce_last   = (cce_cnt_r == cce_w_lp'(num_cce_p - 1));
    assign instr_addr = addr_w_lp'(instr_base_addr_p) + addr_w_lp'(instr_cnt_r);

`ifdef BP_CCE_CFG_VERIFY_EN
    logic [dw_lp-1:0]     data_r;
    logic [dw_lp-1:0]     rd_data;
    logic [num_cce_p-1:0] cce_onehot;
    logic                 rd_v;
    logic                 error_r;

    always_comb begin
        cce_onehot = '0;
        rd_data    = '0;
        for (int i = 0; i < num_cce_p; i++) begin
            cce_onehot[i] = (cce_cnt_r == cce_w_lp'(i));
            if (cce_onehot[i]) rd_data = config_data_i[i*dw_lp +: dw_lp];
        end
    end

    assign rd_v           = |(cce_onehot & config_v_i);
    assign config_ready_o = (state_r == s_rd_wait) ? cce_onehot : '0;
    assign error_o        = error_r;
`else
    logic unused_readback;
    assign unused_readback = ^{config_v_i, config_data_i};
    assign config_ready_o  = '0;
    assign error_o         = 1'b0;
`endif

    always_comb begin
        state_n   = state_r;
        load      = 1'b0;
        load_addr = instr_addr;
        load_data = boot_rom_data_i;
        load_w    = 1'b1;
        word_done = 1'b0;
        case (state_r)
            s_reset:    state_n = s_fetch;
            s_fetch:    state_n = s_rom_wait;
            s_rom_wait: begin
                load    = 1'b1;
                state_n = s_send;
            end
            s_send: begin
                if (fire) begin
`ifdef BP_CCE_CFG_VERIFY_EN
                    load      = 1'b1;
                    load_w    = 1'b0;
                    load_data = data_r;
                    state_n   = s_rd;
`else
                    word_done = 1'b1;
`endif
                end
            end
            s_mode: begin
                if (fire) state_n = cce_last ? s_done : s_fetch;
            end
`ifdef BP_CCE_CFG_VERIFY_EN
            s_rd: begin
                if (fire) state_n = s_rd_wait;
            end
            s_rd_wait: begin
                if (rd_v) word_done = 1'b1;
            end
`endif
            default: state_n = state_r;
        endcase
        // Last word of the image queues the mode write for this CCE.
        if (word_done) begin
            if (instr_last) begin
                state_n   = s_mode;
                load      = 1'b1;
                load_addr = addr_w_lp'(mode_addr_p);
                load_data = dw_lp'(mode_normal_p);
                load_w    = 1'b1;
            end else begin
                state_n = s_fetch;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r     <= s_reset;
            instr_cnt_r <= '0;
            cce_cnt_r   <= '0;
        end else begin
            state_r <= state_n;
            if (word_done) instr_cnt_r <= instr_last ? '0 : instr_cnt_r + 1'b1;
            if (state_r == s_mode && fire && !cce_last) cce_cnt_r <= cce_cnt_r + 1'b1;
        end
    end

`ifdef BP_CCE_CFG_VERIFY_EN
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            data_r  <= '0;
            error_r <= 1'b0;
        end else begin
            if (state_r == s_rom_wait) data_r <= boot_rom_data_i;
            if (state_r == s_rd_wait && rd_v && rd_data != data_r) error_r <= 1'b1;
        end
    end
`endif

    bp_cce_cfg_link_master #(
        .num_cce_p  (num_cce_p),
        .sel_width_p(cce_w_lp),
        .addr_w_p   (addr_w_lp),
        .data_w_p   (dw_lp)
    ) link (
        .clk      (clk_i),
        .reset    (reset_i),
        .load     (load),
        .load_addr(load_addr),
        .load_data(load_data),
        .load_w   (load_w),
        .load_sel (cce_cnt_r),
        .ready    (config_ready_i),
        .addr     (config_addr_o),
        .data     (config_data_o),
        .v        (config_v_o),
        .w        (config_w_o),
        .fire     (fire)
    );

    assign boot_rom_addr_o = instr_cnt_r;
    assign done_o          = (state_r == s_done);
    assign freeze_o        = ~done_o;
    assign state_o         = state_r;

endmodule

// File: doc/bp_cce_cfg_loader.md
Name: bp_cce_cfg_loader

Overview:
- Boot-time sequencer for the ME config channel.
- Streams the CCE microcode image from a shared synchronous boot ROM into each CCE's instruction RAM over the per-CCE config link, one CCE at a time.
- After loading, writes each CCE's mode register to normal mode, then releases freeze.
- Sits beside the ME top-level and drives its config_* inputs and freeze_i.

Parameters:
- num_cce_p, 1, number of CCEs to load.
- num_instr_p, 256, instruction words per image (>=1); also the ROM depth.
- cfg_link_addr_width_p, 16, config link address width; ports carry width-1 bits.
- cfg_link_data_width_p, 64, config link and boot ROM data width.
- instr_base_addr_p, 'h4000, config address of instruction word 0.
- mode_addr_p, 'h0000, config address of the CCE mode register.
- mode_normal_p, 1, value written to the mode register to select normal mode.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-high reset.
- boot_rom_addr_o  out  clog2(num_instr_p)  ROM word address.
- boot_rom_data_i  in  cfg_link_data_width_p  ROM data, valid one cycle after the address.
- config_addr_o  out  num_cce_p x (cfg_link_addr_width_p-1)  per-CCE config address.
- config_data_o  out  num_cce_p x cfg_link_data_width_p  per-CCE write data.
- config_v_o  out  num_cce_p  per-CCE request valid.
- config_w_o  out  num_cce_p  1 = write, 0 = read.
- config_ready_i  in  num_cce_p  per-CCE request ready.
- config_data_i  in  num_cce_p x cfg_link_data_width_p  read-return data.
- config_v_i  in  num_cce_p  read-return valid.
- config_ready_o  out  num_cce_p  read-return ready.
- freeze_o  out  1  holds CCEs frozen until loading completes.
- done_o  out  1  loading complete.
- error_o  out  1  readback mismatch (verify feature only).

Behaviour:
- Reset values: config_v_o=0, config_w_o=0, config_addr_o=0, config_data_o=0, config_ready_o=0, boot_rom_addr_o=0, freeze_o=1, done_o=0, error_o=0. Counters are cleared; state = e_reset.
- Asserting reset_i in any state aborts the load and returns every output to its reset value on the next edge. There is no partial resume.
- States and transitions:
  - e_reset: go to e_fetch on the next cycle.
  - e_fetch: drive boot_rom_addr_o = instr_cnt; go to e_rom_wait.
  - e_rom_wait: capture boot_rom_data_i into data_r. Latency is exactly one cycle. Go to e_send.
  - e_send: assert config_v_o[cce_cnt] with config_w_o=1, addr = instr_base_addr_p + instr_cnt (truncated to cfg_link_addr_width_p-1 bits), data = data_r.
    - All other config_v_o bits stay 0.
    - addr, data and v are held stable until config_ready_i[cce_cnt]=1. The transfer completes on the cycle v & ready.
    - On transfer: if instr_cnt == num_instr_p-1, clear instr_cnt and go to e_mode; otherwise increment instr_cnt and go to e_fetch.
  - e_mode: write mode_normal_p to mode_addr_p for cce_cnt, same hold-until-ready rule.
    - On transfer: if cce_cnt == num_cce_p-1, go to e_done; otherwise increment cce_cnt and go to e_fetch.
  - e_done: freeze_o=0, done_o=1; remain here until reset.
- Throughput: 3 cycles per word with ready held high.
- Total cycles from reset deassertion to done_o=1 with ready held high: 1 + num_cce_p*(3*num_instr_p + 1).
- config_ready_i for a non-selected CCE is ignored.
- Without the verify feature, config_ready_o=0 always, config_v_i is ignored, and error_o stays 0.
- Counter widths:
  - instr_cnt: clog2(num_instr_p), safe for num_instr_p=1.
  - cce_cnt: clog2(num_cce_p), safe for num_cce_p=1.
  - The counters never wrap; terminal compares are used instead.

Optional Feature:
- Macro: BP_CCE_CFG_VERIFY_EN.
- When defined, after each instruction write the loader enters e_rd and issues a read (config_w_o=0) to the same address, same hold-until-ready rule.
- It then enters e_rd_wait with config_ready_o[cce_cnt]=1 until config_v_i[cce_cnt]=1.
- It compares config_data_i against data_r. On a mismatch, error_o latches 1, is sticky until reset, and loading continues.
- The cycle formula becomes 1 + num_cce_p*(3*num_instr_p + 2*num_instr_p + read latency terms + 1).
- When undefined, the e_rd and e_rd_wait states and the compare logic are absent.

Decomposition:
- In bp_cce_pkg:
  - state enum bp_cce_cfg_loader_state_e (e_reset, e_fetch, e_rom_wait, e_send, e_mode, e_rd, e_rd_wait, e_done).
  - constants for instr_base_addr_p, mode_addr_p and mode_normal_p defaults.
- Sub-module bp_cce_cfg_link_master: a single-request valid/ready holding register plus a one-hot fan-out to the CCE selected by cce_cnt. The FSM and counters stay in bp_cce_cfg_loader.

Test Plan:
- num_cce_p=1, num_instr_p=4, ROM[i]=i+'hA0, ready tied 1 -> writes ('h4000,'hA0)..('h4003,'hA3), then ('h0000,1); done_o rises at cycle 14; freeze_o falls in the same cycle.
- num_cce_p=2, num_instr_p=2 -> all CCE0 writes before any CCE1 write; config_v_o never has 2 bits set; the CCE1 writes occur with CCE0 ready forced 0.
- Ready backpressure: config_ready_i[0] low for 5 cycles on word 1 -> addr 'h4001 and data held stable for all 5 cycles; exactly one transfer counted.
- Reset asserted mid-load on word 2 for 1 cycle -> next cycle all outputs at reset values; the reload restarts from word 0 of CCE0.
- With BP_CCE_CFG_VERIFY_EN, readback of word 3 returns data ^ 1 -> error_o=1 sticky; done_o still reaches 1.
- num_instr_p=1, num_cce_p=1 -> one instruction write then the mode write; done_o at cycle 5.
